rom_loader: RTL and testbench

ROM_LOADER -- requirements
Module: rom_loader

---
 rtl/rom_loader.sv | 128 ++++++++++++
 tb/tb_rom_loader.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_loader.sv
// rtl/rom_loader.sv - streams HPS cartridge bytes into SDRAM and builds the console ROM address mask.
// Optional HEADER_STRIP_EN: detect a 512-byte copier header and offset ROM reads past it.
module rom_loader (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        ioctl_download,
   input  logic [7:0]  ioctl_index,
   input  logic        ioctl_wr,
   input  logic [7:0]  ioctl_dout,
   output logic        ioctl_wait,
   output logic        wr_req,
   input  logic        wr_ack,
   output logic [21:0] wr_addr,
   output logic [7:0]  wr_data,
   input  logic [21:0] rd_addr_in,
   output logic [21:0] rd_addr_out,
   output logic        gg,
   output logic        busy,
   output logic        overflow
);
   typedef enum logic [1:0] {IDLE, LOAD, WRITE, FINISH} state_t;

   state_t      state;
   logic        dl_d;
   logic        dl_rise;
   logic [22:0] counter;
   logic [21:0] mask;
   logic [21:0] rom_mask;
   logic        hdr;
   logic        unused;

   assign dl_rise = ioctl_download & ~dl_d;
   assign busy    = (state != IDLE);

`ifdef HEADER_STRIP_EN
   logic [21:0] mask512;
   logic [22:0] counter_m512;
   logic        hdr_next;
   assign counter_m512 = counter - 23'd512;
   assign hdr_next     = (counter[9:0] == 10'd512);
   assign unused       = &{1'b0, ioctl_index[7:5], counter_m512[22]};
`else
   assign hdr    = 1'b0;
   assign unused = &{1'b0, ioctl_index[7:5]};
`endif

   always_ff @(posedge clk_sys) begin
      dl_d <= ioctl_download;
      if (reset) begin
         state      <= IDLE;
         ioctl_wait <= 1'b0;
         overflow   <= 1'b0;
         gg         <= 1'b0;
         wr_req     <= wr_ack;
         wr_addr    <= '0;
         wr_data    <= '0;
         counter    <= '0;
         mask       <= '0;
         rom_mask   <= '1;
`ifdef HEADER_STRIP_EN
         mask512    <= '0;
         hdr        <= 1'b0;
`endif
      end else if (dl_rise) begin
         // A new image always restarts cleanly; any outstanding write is dropped.
         state      <= LOAD;
         ioctl_wait <= 1'b0;
         overflow   <= 1'b0;
         wr_req     <= wr_ack;
         counter    <= '0;
         mask       <= '0;
`ifdef HEADER_STRIP_EN
         mask512    <= '0;
         hdr        <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: ;
            LOAD: begin
               if (!ioctl_download) begin
                  state <= FINISH;
               end else if (ioctl_wr) begin
                  if (!counter[22]) begin
                     wr_data    <= ioctl_dout;
                     wr_addr    <= counter[21:0];
                     wr_req     <= ~wr_req;
                     ioctl_wait <= 1'b1;
                     mask       <= mask | counter[21:0];
`ifdef HEADER_STRIP_EN
                     if (counter >= 23'd512)
                        mask512 <= mask512 | counter_m512[21:0];
`endif
                     if (counter == '0)
                        gg <= (ioctl_index[4:0] == 5'd2);
                     state <= WRITE;
                  end else begin
                     overflow <= 1'b1;
                  end
               end
            end
            WRITE: begin
               if (wr_ack == wr_req) begin
                  ioctl_wait <= 1'b0;
                  counter    <= counter + 23'd1;
                  state      <= ioctl_download ? LOAD : FINISH;
               end
            end
            FINISH: begin
`ifdef HEADER_STRIP_EN
               hdr      <= hdr_next;
               rom_mask <= hdr_next ? mask512 : mask;
`else
               rom_mask <= mask;
`endif
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset)
         rd_addr_out <= '0;
      else
         rd_addr_out <= (rd_addr_in & rom_mask) + (hdr ? 22'd512 : 22'd0);
   end
endmodule

// File: tb/tb_rom_loader.sv
// tb/tb_rom_loader.sv - scoreboard bench for rom_loader with a toggle-handshake SDRAM responder.
module tb_rom_loader;
   logic        clk_sys = 1'b0;
   logic        reset = 1'b1;
   logic        ioctl_download = 1'b0;
   logic [7:0]  ioctl_index = 8'h00;
   logic        ioctl_wr = 1'b0;
   logic [7:0]  ioctl_dout = 8'h00;
   logic        ioctl_wait;
   logic        wr_req;
   logic        wr_ack = 1'b0;
   logic [21:0] wr_addr;
   logic [7:0]  wr_data;
   logic [21:0] rd_addr_in = '0;
   logic [21:0] rd_addr_out;
   logic        gg, busy, overflow;

   int          errors = 0;
   int          checks = 0;
   logic [29:0] exp_q[$];
   int          model_n = 0;
   int          ack_delay = 0;
   int          ack_cnt = 0;
   int          wait_len = 0;
   int          n_toggles = 0;
   bit          check_wait = 1'b1;
   bit          started = 1'b0;
   bit          force_ovf = 1'b0;
   logic        prev_req = 1'b0;

   rom_loader dut (
      .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
      .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_dout(ioctl_dout),
      .ioctl_wait(ioctl_wait), .wr_req(wr_req), .wr_ack(wr_ack),
      .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr_in(rd_addr_in),
      .rd_addr_out(rd_addr_out), .gg(gg), .busy(busy), .overflow(overflow)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor, wait-length checker and SDRAM responder share one process so ordering is fixed.
   always @(negedge clk_sys) begin
      logic [29:0] e;
      if (started && wr_req !== prev_req && wr_req !== wr_ack) begin
         n_toggles++;
         if (exp_q.size() == 0) begin
            chk("unexpected_wr_req_toggle", 1, 0);
         end else begin
            e = exp_q.pop_front();
            chk("wr_addr", wr_addr, e[29:8]);
            chk("wr_data", wr_data, e[7:0]);
         end
      end
      prev_req = wr_req;
      if (ioctl_wait === 1'b1) begin
         wait_len++;
      end else if (wait_len != 0) begin
         if (check_wait) chk("ioctl_wait_cycles", wait_len, ack_delay + 1);
         wait_len = 0;
      end
      if (started && wr_req !== wr_ack) begin
         if (ack_cnt >= ack_delay) begin
            wr_ack = wr_req;
            ack_cnt = 0;
         end else begin
            ack_cnt++;
         end
      end else begin
         ack_cnt = 0;
      end
   end

   function automatic logic [21:0] or_range(input int hi);
      logic [21:0] r = '0;
      for (int i = 0; i <= hi; i++) r |= 22'(i);
      return r;
   endfunction

   function automatic logic [21:0] exp_rd(input logic [21:0] a, input int n);
      bit h;
      logic [21:0] m;
`ifdef HEADER_STRIP_EN
      h = ((n % 1024) == 512);
`else
      h = 1'b0;
`endif
      m = h ? or_range(n - 513) : or_range(n - 1);
      return (a & m) + (h ? 22'd512 : 22'd0);
   endfunction

   task automatic send_byte(input logic [7:0] d);
      int c = 0;
      if (!force_ovf) begin
         exp_q.push_back({22'(model_n), d});
         model_n++;
      end
      ioctl_dout = d;
      ioctl_wr = 1'b1;
      @(negedge clk_sys);
      ioctl_wr = 1'b0;
      while (ioctl_wait && c < 100) begin
         @(negedge clk_sys);
         c++;
      end
      chk("ioctl_wait_timeout", ioctl_wait, 0);
   endtask

   task automatic wait_idle();
      int c = 0;
      while (busy && c < 200) begin
         @(negedge clk_sys);
         c++;
      end
      chk("busy_timeout", busy, 0);
   endtask

   task automatic check_rd(input int n);
      logic [31:0] v;
      for (int k = 0; k < 3; k++) begin
         v = $urandom;
         rd_addr_in = v[21:0];
         @(negedge clk_sys);
         chk("rd_addr_out", rd_addr_out, exp_rd(v[21:0], n));
      end
   endtask

   task automatic check_finish(input logic [7:0] idx, input int n, input bit ovf);
      chk("busy_after_finish", busy, 0);
      chk("gg", gg, (idx[4:0] == 5'd2));
      chk("overflow", overflow, ovf);
      check_rd(n);
   endtask

   task automatic start_download(input logic [7:0] idx);
      ioctl_index = idx;
      ioctl_download = 1'b1;
      model_n = 0;
      @(negedge clk_sys);
   endtask

   task automatic run_download(input int n, input logic [7:0] idx);
      start_download(idx);
      for (int i = 0; i < n; i++) send_byte(8'($urandom));
      ioctl_download = 1'b0;
      wait_idle();
      check_finish(idx, n, 1'b0);
   endtask

   initial begin
      int t0;
      int c;
      logic rq;
      rd_addr_in = 22'h3ABCDE;
      repeat (3) @(negedge clk_sys);
      chk("rst_ioctl_wait", ioctl_wait, 0);
      chk("rst_busy", busy, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_gg", gg, 0);
      chk("rst_wr_req", wr_req, wr_ack);
      chk("rst_wr_addr", wr_addr, 0);
      chk("rst_wr_data", wr_data, 0);
      chk("rst_rd_addr_out", rd_addr_out, 0);
      reset = 1'b0;
      started = 1'b1;
      @(negedge clk_sys);
      chk("rst_rom_mask_ones", rd_addr_out, 22'h3ABCDE);

      // 32 KiB image, immediate acknowledge
      ack_delay = 0;
      t0 = n_toggles;
      run_download(32768, 8'h00);
      chk("toggles_32k", n_toggles - t0, 32768);
      rd_addr_in = 22'h12345;
      @(negedge clk_sys);
      chk("rd_32k_fixed", rd_addr_out, 22'h02345);

      // image sized like a 512-byte copier header plus 1 KiB
      run_download(1536, 8'h01);
      rd_addr_in = 22'h0;
      @(negedge clk_sys);
`ifdef HEADER_STRIP_EN
      chk("rd_hdr_zero", rd_addr_out, 22'h200);
`else
      chk("rd_hdr_zero", rd_addr_out, 22'h0);
`endif

      // slow SDRAM and Game Gear index
      ack_delay = 7;
      run_download(20, 8'h22);

      // download falls while a write is still pending
      ack_delay = 3;
      start_download(8'h00);
      exp_q.push_back({22'd0, 8'hA5});
      ioctl_dout = 8'hA5;
      ioctl_wr = 1'b1;
      @(negedge clk_sys);
      ioctl_wr = 1'b0;
      ioctl_download = 1'b0;
      c = 0;
      while (ioctl_wait && c < 100) begin
         @(negedge clk_sys);
         c++;
      end
      chk("drop_wait_low", ioctl_wait, 0);
      chk("drop_finish_busy", busy, 1);
      @(negedge clk_sys);
      chk("drop_idle_busy", busy, 0);
      check_finish(8'h00, 1, 1'b0);

      // reset while a write is outstanding
      ack_delay = 50;
      check_wait = 1'b0;
      start_download(8'h02);
      exp_q.push_back({22'd0, 8'h3C});
      ioctl_dout = 8'h3C;
      ioctl_wr = 1'b1;
      @(negedge clk_sys);
      ioctl_wr = 1'b0;
      chk("rstw_wait_high", ioctl_wait, 1);
      reset = 1'b1;
      ioctl_download = 1'b0;
      @(negedge clk_sys);
      chk("rstw_wait", ioctl_wait, 0);
      chk("rstw_busy", busy, 0);
      chk("rstw_req_sync", wr_req, wr_ack);
      reset = 1'b0;
      rq = wr_req;
      repeat (5) @(negedge clk_sys);
      chk("rstw_no_toggle", wr_req, rq);
      chk("rstw_gg", gg, 0);
      check_wait = 1'b1;
      ack_delay = 0;

      // counter pinned at 4 MiB
      start_download(8'h02);
      for (int i = 0; i < 3; i++) send_byte(8'($urandom));
      force dut.counter = 23'h400000;
      force_ovf = 1'b1;
      rq = wr_req;
      send_byte(8'h77);
      chk("ovf_flag", overflow, 1);
      chk("ovf_wait", ioctl_wait, 0);
      chk("ovf_no_toggle", wr_req, rq);
      force_ovf = 1'b0;
      release dut.counter;
      ioctl_download = 1'b0;
      wait_idle();
      check_finish(8'h02, 3, 1'b1);

      // randomized images
      for (int r = 0; r < 4; r++) begin
         ack_delay = $urandom_range(0, 3);
         run_download($urandom_range(1, 400), 8'($urandom));
      end

      chk("scoreboard_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
